// File: rtl/random_target_sequencer.sv
// Pulls SEQ_LEN folded random values from the LFSR generator, then plays them as timed
// targets (ON_CYCLES shown, OFF_CYCLES blank); a stored sequence can be replayed.
module random_target_sequencer #(
  parameter int SEQ_LEN     = 8,
  parameter int NUM_TARGETS = 10,
  parameter int ON_CYCLES   = 25_000_000,
  parameter int OFF_CYCLES  = 12_500_000
) (
  input  logic       clk,
  input  logic       res,
  input  logic       start,
  input  logic       replay,
  input  logic       abort,
  input  logic [3:0] rand_num,
  output logic       rand_enable,
  output logic       busy,
  output logic       target_valid,
  output logic [3:0] target,
  output logic [3:0] seq_index,
  output logic       done
);

  localparam int MAX_DWELL = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int CNT_W     = (MAX_DWELL > 1) ? $clog2(MAX_DWELL) : 1;

  localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(OFF_CYCLES - 1);
  localparam logic [3:0]       LAST_IDX = 4'(SEQ_LEN - 1);
  localparam logic [4:0]       NT_W5    = 5'(NUM_TARGETS);
  localparam logic [3:0]       NT_W4    = 4'(NUM_TARGETS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL_REQ,
    S_FILL_CAP,
    S_PLAY_ON,
    S_PLAY_OFF,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             seq_valid_q, seq_valid_d;
  logic             mem_we;
  logic [3:0]       fold_val;

  // Sized to the full 4-bit index range so idx_q indexes it without truncation.
  logic [3:0] seq_mem_q [16];

  // A single subtraction suffices: rand_num < 16 <= 2*NUM_TARGETS.
  assign fold_val = ({1'b0, rand_num} < NT_W5) ? rand_num : (rand_num - NT_W4);

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      seq_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      seq_valid_q <= seq_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      seq_mem_q[idx_q] <= fold_val;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    seq_valid_d  = seq_valid_q;
    mem_we       = 1'b0;
    rand_enable  = 1'b0;
    busy         = 1'b0;
    target_valid = 1'b0;
    target       = '0;
    seq_index    = '0;
    done         = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        done = (state_q == S_DONE);
        if (start) begin
          state_d = S_FILL_REQ;
          idx_d   = '0;
        end else if (replay && seq_valid_q) begin
          state_d = S_PLAY_ON;
          idx_d   = '0;
          cnt_d   = ON_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_FILL_REQ: begin
        busy        = 1'b1;
        rand_enable = 1'b1;
        seq_index   = idx_q;
        state_d     = S_FILL_CAP;
      end

      S_FILL_CAP: begin
        busy      = 1'b1;
        seq_index = idx_q;
        mem_we    = 1'b1;
        if (idx_q == LAST_IDX) begin
          seq_valid_d = 1'b1;
          idx_d       = '0;
          cnt_d       = ON_LOAD;
          state_d     = S_PLAY_ON;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = S_FILL_REQ;
        end
      end

      S_PLAY_ON: begin
        busy         = 1'b1;
        target_valid = 1'b1;
        target       = seq_mem_q[idx_q];
        seq_index    = idx_q;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          cnt_d   = OFF_LOAD;
          state_d = S_PLAY_OFF;
        end
      end

      S_PLAY_OFF: begin
        busy      = 1'b1;
        seq_index = idx_q;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          idx_d   = idx_q + 4'd1;
          cnt_d   = ON_LOAD;
          state_d = S_PLAY_ON;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A partially filled buffer must never be replayed; a played one stays valid.
    if (busy && abort) begin
      state_d = S_IDLE;
      idx_d   = '0;
      mem_we  = 1'b0;
      if (state_q == S_FILL_REQ || state_q == S_FILL_CAP) begin
        seq_valid_d = 1'b0;
      end else begin
        seq_valid_d = seq_valid_q;
      end
    end
  end

endmodule
